// File: rtl/miner_ctrl_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : miner_pkg
//  Purpose  : Shared types and helpers for the multi-core miner controller:
//             default nonce width, FSM state encoding, per-core nonce stride.
//  Revision : 1.0 - initial release
// ============================================================================
package miner_pkg;

  localparam int c_nonce_w_default = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WARM = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Distance between neighbouring cores' start nonces: 2^nonce_w / num_cores
  function automatic logic [63:0] core_stride(input int nonce_w, input int num_cores);
    return (64'd1 << nonce_w) / 64'(num_cores);
  endfunction

endpackage
`default_nettype wire

// File: rtl/miner_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : miner_ctrl_multi_if
//  Purpose  : Host-side bundle of the miner controller: work delivery from
//             the serial receiver and the send handshake to the transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
interface miner_ctrl_multi_if
  import miner_pkg::*;
#(
  parameter int NONCE_W = c_nonce_w_default
) ();

  logic               work_valid;
  logic [NONCE_W-1:0] nonce_base;
  logic               tx_send;
  logic [NONCE_W-1:0] tx_word;
  logic               tx_busy;

  // Host / serial side
  modport master (output work_valid, output nonce_base, output tx_busy,
                  input  tx_send,    input  tx_word);

  // Miner controller side
  modport slave  (input  work_valid, input  nonce_base, input  tx_busy,
                  output tx_send,    output tx_word);

endinterface
`default_nettype wire

// File: rtl/miner_ctrl_multi_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : result_fifo
//  Purpose  : Synchronous result FIFO with flush. A push while full is
//             accepted when a pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && !empty && !flush;
  assign w_push_ok = push && !flush && (!full || w_pop_ok);

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/miner_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module   : miner_ctrl_multi
//  Purpose  : Multi-core miner control: splits the nonce space across cores,
//             sequences core reset/warm-up, collects golden nonces from cores
//             and the chain port, queues them and drains to the transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module miner_ctrl_multi
  import miner_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int NONCE_W      = c_nonce_w_default,
  parameter int FIFO_DEPTH   = 4,
  parameter int WARMUP_CYC   = 62,
  parameter int STOP_ON_FIND = 1,
  parameter int CHAIN_EN     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  miner_ctrl_multi_if.slave            bus,
  output logic                         core_rst,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce_start,
  input  logic [NUM_CORES-1:0]         core_ready,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  input  logic                         chain_valid,
  input  logic [NONCE_W-1:0]           chain_nonce,
  output logic                         running,
  output logic [7:0]                   drop_cnt
);

  localparam logic [63:0] c_stride = core_stride(NONCE_W, NUM_CORES);
  localparam int          c_wcnt_w = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

  state_t                      r_state;
  logic [c_wcnt_w-1:0]         r_wcnt;
  logic [NUM_CORES-1:0]        r_pend;
  logic [NUM_CORES-1:0]        r_seen;
  logic [NONCE_W-1:0]          r_pnonce [NUM_CORES];
  logic                        r_pend_chain;
  logic [NONCE_W-1:0]          r_chain_nonce;
  logic [1:0]                  r_hold;

  logic [NUM_CORES*NONCE_W-1:0] w_starts;
  logic [NUM_CORES-1:0]         w_cap;
  logic                         w_chain_cap;
  logic                         w_drain;
  logic [NONCE_W-1:0]           w_drain_data;
  logic [NUM_CORES-1:0]         w_clr_core;
  logic                         w_clr_chain;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_drop;
  logic                         w_full;
  logic                         w_empty;
  logic [NONCE_W-1:0]           w_head;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_start
    localparam logic [63:0] c_off = 64'(gi) * c_stride;
    assign w_starts[gi*NONCE_W +: NONCE_W] = bus.nonce_base + c_off[NONCE_W-1:0];
  end

  // Level-held strobes count once thanks to the seen flags
  assign w_cap       = (r_state == RUN) ? (core_ready & ~r_seen) : '0;
  assign w_chain_cap = (CHAIN_EN != 0) && chain_valid;

  // Pick one pending source per cycle: lowest core index first, chain last
  always_comb begin
    w_drain      = 1'b0;
    w_drain_data = '0;
    w_clr_core   = '0;
    w_clr_chain  = 1'b0;
    if (r_pend_chain) begin
      w_drain      = 1'b1;
      w_drain_data = r_chain_nonce;
      w_clr_chain  = 1'b1;
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_drain       = 1'b1;
        w_drain_data  = r_pnonce[i];
        w_clr_core    = '0;
        w_clr_core[i] = 1'b1;
        w_clr_chain   = 1'b0;
      end
    end
  end

  // New work flushes the queue, so nothing is pushed or popped that cycle
  assign w_push = w_drain && !bus.work_valid;
  assign w_pop  = !w_empty && !bus.tx_busy && (r_hold == 2'd0) && !bus.work_valid;
  assign w_drop = w_push && w_full && !w_pop;

  result_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.work_valid),
    .push      (w_push),
    .push_data (w_drain_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Control FSM: core reset sequencing, warm-up timing, stop-on-find
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_wcnt           <= '0;
      core_rst         <= 1'b1;
      running          <= 1'b0;
      core_nonce_start <= '0;
    end else if (bus.work_valid) begin
      r_state          <= ARM;
      r_wcnt           <= '0;
      core_rst         <= 1'b1;
      running          <= 1'b0;
      core_nonce_start <= w_starts;
    end else begin
      case (r_state)
        IDLE: begin
          core_rst <= 1'b1;
          running  <= 1'b0;
        end
        ARM: begin
          r_state  <= WARM;
          r_wcnt   <= '0;
          core_rst <= 1'b0;
        end
        WARM: begin
          if (r_wcnt == c_wcnt_w'(WARMUP_CYC - 1)) begin
            r_state <= RUN;
            running <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + c_wcnt_w'(1);
          end
        end
        RUN: begin
          if ((STOP_ON_FIND != 0) && (|w_cap)) begin
            r_state  <= IDLE;
            core_rst <= 1'b1;
            running  <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          core_rst <= 1'b1;
          running  <= 1'b0;
        end
      endcase
    end
  end

  // Result capture into pending latches; set beats the drain clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend        <= '0;
      r_seen        <= '0;
      r_pend_chain  <= 1'b0;
      r_chain_nonce <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_pnonce[i] <= '0;
    end else if (bus.work_valid) begin
      r_pend       <= '0;
      r_seen       <= '0;
      r_pend_chain <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_cap[i]) begin
          r_pend[i]   <= 1'b1;
          r_seen[i]   <= 1'b1;
          r_pnonce[i] <= core_nonce[i*NONCE_W +: NONCE_W];
        end else if (w_clr_core[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (w_chain_cap) begin
        r_pend_chain  <= 1'b1;
        r_chain_nonce <= chain_nonce;
      end else if (w_clr_chain) begin
        r_pend_chain <= 1'b0;
      end
    end
  end

  // Transmit handshake; holdoff gives the transmitter time to raise busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_send <= 1'b0;
      bus.tx_word <= '0;
      r_hold      <= 2'd0;
    end else if (w_pop) begin
      bus.tx_send <= 1'b1;
      bus.tx_word <= w_head;
      r_hold      <= 2'd2;
    end else begin
      bus.tx_send <= 1'b0;
      if (r_hold != 2'd0) r_hold <= r_hold - 2'd1;
    end
  end

  // Saturating count of results lost to a full queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 8'd0;
    end else if (w_drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miner_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_miner_ctrl_multi
//  Purpose  : Self-checking bench. Instance A: stop-on-find, 4-deep FIFO,
//             62-cycle warm-up. Instance B: continuous mining, 2-deep FIFO,
//             8-cycle warm-up. Transmitted words are scored against queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_miner_ctrl_multi;

  logic clk;
  logic rst_n;

  miner_ctrl_multi_if #(.NONCE_W(32)) if_a ();
  miner_ctrl_multi_if #(.NONCE_W(32)) if_b ();

  logic         core_rst_a, core_rst_b;
  logic [127:0] start_a, start_b;
  logic [3:0]   core_ready_a, core_ready_b;
  logic [127:0] core_nonce_a, core_nonce_b;
  logic         chain_valid_a, chain_valid_b;
  logic [31:0]  chain_nonce_a, chain_nonce_b;
  logic         running_a, running_b;
  logic [7:0]   drop_a, drop_b;

  int          checks = 0;
  int          errors = 0;
  int          sends_a = 0;
  int          sends_b = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  bit          force_a = 0;
  bit          force_b = 0;

  miner_ctrl_multi #(
    .NUM_CORES(4), .NONCE_W(32), .FIFO_DEPTH(4), .WARMUP_CYC(62),
    .STOP_ON_FIND(1), .CHAIN_EN(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a), .core_rst(core_rst_a),
    .core_nonce_start(start_a), .core_ready(core_ready_a), .core_nonce(core_nonce_a),
    .chain_valid(chain_valid_a), .chain_nonce(chain_nonce_a),
    .running(running_a), .drop_cnt(drop_a)
  );

  miner_ctrl_multi #(
    .NUM_CORES(4), .NONCE_W(32), .FIFO_DEPTH(2), .WARMUP_CYC(8),
    .STOP_ON_FIND(0), .CHAIN_EN(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b), .core_rst(core_rst_b),
    .core_nonce_start(start_b), .core_ready(core_ready_b), .core_nonce(core_nonce_b),
    .chain_valid(chain_valid_b), .chain_nonce(chain_nonce_b),
    .running(running_b), .drop_cnt(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model + scoreboard for A: busy for 4 cycles after each send
  initial begin
    int cnt;
    logic [31:0] exp;
    cnt = 0;
    if_a.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (if_a.tx_send) begin
        sends_a++;
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_tx_word got %h expected no send", if_a.tx_word);
        end else begin
          exp = q_a.pop_front();
          if (if_a.tx_word !== exp) begin
            errors++;
            $display("FAIL a_tx_word got %h expected %h", if_a.tx_word, exp);
          end
        end
        cnt = 4;
      end else if (cnt > 0) begin
        cnt--;
      end
      if_a.tx_busy = force_a || (cnt != 0);
    end
  end

  // Transmitter model + scoreboard for B
  initial begin
    int cnt;
    logic [31:0] exp;
    cnt = 0;
    if_b.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (if_b.tx_send) begin
        sends_b++;
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_tx_word got %h expected no send", if_b.tx_word);
        end else begin
          exp = q_b.pop_front();
          if (if_b.tx_word !== exp) begin
            errors++;
            $display("FAIL b_tx_word got %h expected %h", if_b.tx_word, exp);
          end
        end
        cnt = 4;
      end else if (cnt > 0) begin
        cnt--;
      end
      if_b.tx_busy = force_b || (cnt != 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_a(input logic [31:0] base);
    if_a.nonce_base = base;
    if_a.work_valid = 1'b1;
    cycles(1);
    if_a.work_valid = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] base);
    if_b.nonce_base = base;
    if_b.work_valid = 1'b1;
    cycles(1);
    if_b.work_valid = 1'b0;
  endtask

  task automatic start_run_b(input logic [31:0] base);
    int n;
    pulse_b(base);
    n = 0;
    while (!running_b && n < 100) begin cycles(1); n++; end
    checks++;
    if (!running_b) begin
      errors++;
      $display("FAIL b_run_timeout got running=%0b expected 1", running_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    checks++; if (core_rst_a !== 1'b1) begin errors++; $display("FAIL rst_core_rst_a got %b expected 1", core_rst_a); end
    checks++; if (running_a !== 1'b0) begin errors++; $display("FAIL rst_running_a got %b expected 0", running_a); end
    checks++; if (if_a.tx_send !== 1'b0) begin errors++; $display("FAIL rst_tx_send_a got %b expected 0", if_a.tx_send); end
    checks++; if (if_a.tx_word !== 32'h0) begin errors++; $display("FAIL rst_tx_word_a got %h expected 0", if_a.tx_word); end
    checks++; if (start_a !== 128'h0) begin errors++; $display("FAIL rst_start_a got %h expected 0", start_a); end
    checks++; if (drop_a !== 8'h0) begin errors++; $display("FAIL rst_drop_a got %h expected 0", drop_a); end
    checks++; if (core_rst_b !== 1'b1) begin errors++; $display("FAIL rst_core_rst_b got %b expected 1", core_rst_b); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_nonce_split();
    int n;
    pulse_a(32'h0000_0010);
    checks++; if (start_a[0 +: 32] !== 32'h0000_0010) begin errors++; $display("FAIL split_core0 got %h expected 00000010", start_a[0 +: 32]); end
    checks++; if (start_a[32 +: 32] !== 32'h4000_0010) begin errors++; $display("FAIL split_core1 got %h expected 40000010", start_a[32 +: 32]); end
    checks++; if (start_a[64 +: 32] !== 32'h8000_0010) begin errors++; $display("FAIL split_core2 got %h expected 80000010", start_a[64 +: 32]); end
    checks++; if (start_a[96 +: 32] !== 32'hC000_0010) begin errors++; $display("FAIL split_core3 got %h expected c0000010", start_a[96 +: 32]); end
    checks++; if (core_rst_a !== 1'b1) begin errors++; $display("FAIL arm_core_rst got %b expected 1", core_rst_a); end
    cycles(1);
    checks++; if (core_rst_a !== 1'b0) begin errors++; $display("FAIL warm_core_rst got %b expected 0", core_rst_a); end
    n = 0;
    while (!running_a && n < 200) begin cycles(1); n++; end
    checks++; if (n != 62) begin errors++; $display("FAIL warmup_len got %0d expected 62", n); end
  endtask

  task automatic test_stop_on_find();
    int n;
    core_nonce_a[64 +: 32] = 32'h8000_1234;
    core_ready_a = 4'b0100;
    q_a.push_back(32'h8000_1234);
    cycles(1);
    checks++; if (core_rst_a !== 1'b1) begin errors++; $display("FAIL stop_core_rst got %b expected 1", core_rst_a); end
    checks++; if (running_a !== 1'b0) begin errors++; $display("FAIL stop_running got %b expected 0", running_a); end
    n = 1;
    while (!if_a.tx_send && n < 20) begin cycles(1); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL stop_latency got %0d expected 3", n); end
    checks++; if (if_a.tx_word !== 32'h8000_1234) begin errors++; $display("FAIL stop_tx_word got %h expected 80001234", if_a.tx_word); end
    core_ready_a = 4'b0000;
    cycles(10);
  endtask

  task automatic test_warm_reset();
    int s;
    s = sends_a;
    pulse_a(32'h0000_0100);
    cycles(2);
    core_nonce_a = {32'h0000_0D03, 32'h0000_0D02, 32'h0000_0D01, 32'h0000_0D00};
    core_ready_a = 4'hF;
    cycles(5);
    core_ready_a = 4'h0;
    cycles(5);
    checks++; if (sends_a != s) begin errors++; $display("FAIL warm_sends got %0d expected %0d", sends_a, s); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (core_rst_a !== 1'b1) begin errors++; $display("FAIL async_core_rst got %b expected 1", core_rst_a); end
    checks++; if (start_a !== 128'h0) begin errors++; $display("FAIL async_start got %h expected 0", start_a); end
    checks++; if (if_a.tx_word !== 32'h0) begin errors++; $display("FAIL async_tx_word got %h expected 0", if_a.tx_word); end
    checks++; if (running_a !== 1'b0) begin errors++; $display("FAIL async_running got %b expected 0", running_a); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    cycles(5);
  endtask

  task automatic test_multi_source();
    int s;
    int n;
    s = sends_b;
    start_run_b(32'h0000_0000);
    core_nonce_b[0 +: 32]  = 32'h0000_0AAA;
    core_nonce_b[96 +: 32] = 32'hC000_0BBB;
    core_ready_b  = 4'b1001;
    chain_nonce_b = 32'hDEAD_BEEF;
    chain_valid_b = 1'b1;
    q_b.push_back(32'h0000_0AAA);
    q_b.push_back(32'hC000_0BBB);
    q_b.push_back(32'hDEAD_BEEF);
    cycles(1);
    chain_valid_b = 1'b0;
    n = 0;
    while (q_b.size() != 0 && n < 200) begin cycles(1); n++; end
    cycles(20);
    checks++; if (sends_b - s != 3) begin errors++; $display("FAIL multi_sends got %0d expected 3", sends_b - s); end
    checks++; if (running_b !== 1'b1) begin errors++; $display("FAIL multi_running got %b expected 1", running_b); end
    checks++; if (drop_b !== 8'd0) begin errors++; $display("FAIL multi_drop got %0d expected 0", drop_b); end
    core_ready_b = 4'b0000;
  endtask

  task automatic test_overflow();
    int s;
    int n;
    start_run_b(32'h0000_0000);
    s = sends_b;
    force_b = 1'b1;
    cycles(2);
    core_nonce_b  = {32'hC000_0004, 32'h8000_0333, 32'h4000_0222, 32'h0000_0111};
    core_ready_b  = 4'b0111;
    chain_nonce_b = 32'h0000_0444;
    chain_valid_b = 1'b1;
    q_b.push_back(32'h0000_0111);
    q_b.push_back(32'h4000_0222);
    cycles(1);
    chain_valid_b = 1'b0;
    cycles(8);
    checks++; if (drop_b !== 8'd2) begin errors++; $display("FAIL ovf_drop got %0d expected 2", drop_b); end
    checks++; if (sends_b != s) begin errors++; $display("FAIL ovf_blocked got %0d expected 0", sends_b - s); end
    force_b = 1'b0;
    n = 0;
    while (q_b.size() != 0 && n < 200) begin cycles(1); n++; end
    cycles(20);
    checks++; if (sends_b - s != 2) begin errors++; $display("FAIL ovf_sends got %0d expected 2", sends_b - s); end
    core_ready_b = 4'b0000;
  endtask

  task automatic test_flush();
    int s;
    start_run_b(32'h0000_0020);
    s = sends_b;
    force_b = 1'b1;
    cycles(2);
    core_nonce_b = {32'hC000_0099, 32'h8000_0099, 32'h4000_0077, 32'h0000_0066};
    core_ready_b = 4'b0011;
    cycles(4);
    core_ready_b = 4'b0000;
    pulse_b(32'h1000_0000);
    checks++; if (start_b[0 +: 32] !== 32'h1000_0000) begin errors++; $display("FAIL flush_core0 got %h expected 10000000", start_b[0 +: 32]); end
    checks++; if (start_b[96 +: 32] !== 32'hD000_0000) begin errors++; $display("FAIL flush_core3 got %h expected d0000000", start_b[96 +: 32]); end
    checks++; if (core_rst_b !== 1'b1) begin errors++; $display("FAIL flush_core_rst got %b expected 1", core_rst_b); end
    force_b = 1'b0;
    cycles(30);
    checks++; if (sends_b != s) begin errors++; $display("FAIL flush_sends got %0d expected 0", sends_b - s); end
    checks++; if (drop_b !== 8'd2) begin errors++; $display("FAIL flush_drop got %0d expected 2", drop_b); end
  endtask

  initial begin
    if_a.work_valid = 1'b0; if_a.nonce_base = '0;
    if_b.work_valid = 1'b0; if_b.nonce_base = '0;
    core_ready_a = '0; core_nonce_a = '0; chain_valid_a = 1'b0; chain_nonce_a = '0;
    core_ready_b = '0; core_nonce_b = '0; chain_valid_b = 1'b0; chain_nonce_b = '0;
    test_reset();
    test_nonce_split();
    test_stop_on_find();
    test_warm_reset();
    test_multi_source();
    test_overflow();
    test_flush();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d expected 0", q_a.size() + q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/miner_ctrl_multi.md
Name: miner_ctrl_multi

Overview:
Parametrised successor to the single-core miner control unit. Accepts a work-valid pulse from the serial receiver and fans the nonce space out across NUM_CORES Groestl hash cores. It holds cores in reset through an arm/warm-up sequence, then collects golden nonces from every core and from the expansion-port chain receiver. Results are queued in a result FIFO and drained to the serial transmitter. A mode parameter selects stop-on-first-find (legacy behaviour) or continuous mining.

Parameters:
NUM_CORES, 4, number of hash cores; power of two, 1..16
NONCE_W, 32, nonce width in bits
FIFO_DEPTH, 4, result FIFO entries; power of two, 2..16
WARMUP_CYC, 62, cycles cores run after reset release before results are honoured
STOP_ON_FIND, 1, 1 = stop all cores on first result; 0 = keep mining
CHAIN_EN, 1, 1 = accept chain_valid/chain_nonce; 0 = ignore the chain inputs

Ports:
clk  in  1  system clock (PLL c0)
rst_n  in  1  asynchronous active-low reset
work_valid  in  1  1-cycle pulse: new work latched by serial receiver
nonce_base  in  NONCE_W  starting nonce from host, sampled on work_valid
core_rst  out  1  active-high reset to all cores
core_nonce_start  out  NUM_CORES*NONCE_W  per-core start nonce; slice i belongs to core i
core_ready  in  NUM_CORES  per-core result strobe (level, held until core_rst)
core_nonce  in  NUM_CORES*NONCE_W  per-core result nonce, valid while core_ready[i]=1
chain_valid  in  1  1-cycle pulse from expansion-port receiver
chain_nonce  in  NONCE_W  chain result nonce, valid with chain_valid
tx_send  out  1  1-cycle send pulse to serial transmitter
tx_word  out  NONCE_W  nonce to transmit; stable from tx_send until tx_busy falls
tx_busy  in  1  serial transmitter busy
running  out  1  high in RUN state
drop_cnt  out  8  saturating count of results lost to FIFO overflow

Behaviour:
- Reset (rst_n=0, async): state=IDLE, core_rst=1, tx_send=0, tx_word=0, core_nonce_start=0, running=0, drop_cnt=0, FIFO empty, pending latches and per-core seen flags clear.
- Nonce split: core i start = nonce_base + i*(2^NONCE_W/NUM_CORES), mod 2^NONCE_W. Registered on work_valid.
- FSM states:
  - IDLE: core_rst=1; waits for work_valid.
  - ARM: 1 cycle; core_rst=1; start nonces stable.
  - WARM: core_rst=0; counter runs WARMUP_CYC cycles; core_ready ignored; then RUN.
  - RUN: running=1; results captured.
- work_valid in any state: next state ARM, core_rst=1 next cycle, pending latches and seen flags cleared, FIFO flushed. A tx transfer already in flight completes; tx_word holds until then.
- Capture in RUN: core_ready[i] rising (seen flag clear) sets pending[i] with core_nonce[i] registered; seen flag set so a level-held strobe counts once.
- Chain capture: if CHAIN_EN=1, chain_valid sets pending_chain in any state except reset.
- Drain: one pending source moves into the FIFO per cycle. Priority is lowest core index first, chain last. If the FIFO is full, the entry is dropped, its pending flag cleared, and drop_cnt incremented (saturates at 255).
- STOP_ON_FIND=1: the first captured core result moves RUN->IDLE (core_rst=1 next cycle). Results captured in the same cycle are still queued.
- STOP_ON_FIND=0: stays in RUN. The core that fired is not re-enabled, but the others continue.
- TX: when FIFO non-empty, tx_busy=0 and no holdoff, pop the head to tx_word and pulse tx_send for one cycle. tx_busy is ignored for the following 2 cycles (holdoff), then the next pop waits for tx_busy=0.
- Latency: core_ready edge -> pending 1 clk -> FIFO 1 clk -> tx_send 1 clk minimum (3 clk).
- FIFO: simultaneous push and pop allowed when full (pop frees the slot the same cycle). Pointers wrap mod FIFO_DEPTH.

Decomposition:
- Package miner_pkg: NONCE_W default, state encoding (IDLE, ARM, WARM, RUN), and a function computing the core stride.
- Sub-module result_fifo (parametrised width/depth, sync FIFO with full/empty and push-when-full-with-pop).
- Priority selection and FSM stay in the top module.

Test Plan:
- NUM_CORES=4, work_valid with nonce_base=0x10 -> starts 0x10, 0x40000010, 0x80000010, 0xC0000010; core_rst low 2 clk after the pulse; running rises after WARMUP_CYC.
- STOP_ON_FIND=1, core_ready[2]=1 with nonce 0x80001234 in RUN -> tx_send 3 clk later with tx_word=0x80001234; core_rst=1 next clk; state IDLE.
- STOP_ON_FIND=0, cores 0 and 3 ready in the same cycle plus chain_valid (0xDEADBEEF) -> three sends in order: core0, core3, 0xDEADBEEF; each gated by tx_busy.
- FIFO_DEPTH=2, tx_busy held high, 4 results -> 2 queued, drop_cnt=2; release tx_busy -> exactly 2 sends.
- work_valid mid-RUN with 2 queued entries -> FIFO flushed, no further tx_send, ARM entered, new starts loaded.
- rst_n asserted during WARM -> all outputs at reset values immediately; core_ready during WARM produces no result.
